fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the immediate sign-extender and decoder.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a small FIFO and presents instr/PC to decode with valid/ready.
- Applies branch redirects: target = branch PC + sign-extended immediate (immop from the sign-extender), squashing wrong-path fetches.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues word fetches to instruction memory,
// buffers returned words in a small FIFO and applies branch redirects.
module fetch_unit #(
  parameter int                 A_WIDTH  = 32,
  parameter int                 D_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0,
  parameter int                 DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [A_WIDTH-1:0] imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [D_WIDTH-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [D_WIDTH-1:0] instr,
  output logic [A_WIDTH-1:0] instr_pc,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  input  logic [D_WIDTH-1:0] immop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [A_WIDTH-1:0] pc;
  logic               running;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      fifo_count;
  logic [PW-1:0]      fifo_wr;
  logic [PW-1:0]      fifo_rd;
  logic [PW-1:0]      tag_wr;
  logic [PW-1:0]      tag_rd;
  logic [D_WIDTH-1:0] fifo_data [DEPTH];
  logic [A_WIDTH-1:0] fifo_pc   [DEPTH];
  logic [A_WIDTH-1:0] tag_q     [DEPTH];

  logic [CW:0]        inflight;
  logic               req_fire;
  logic               rsp_fire;
  logic               push;
  logic               pop;
  logic [CW-1:0]      outstanding_nxt;
  logic [A_WIDTH-1:0] imm_ext;
  logic [A_WIDTH-1:0] target_sum;
  logic [A_WIDTH-1:0] target;

  // running holds requests off while reset is asserted and releases them on the first clock after.
  assign inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = running && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is illegal and simply ignored.
  assign rsp_fire        = imem_rsp_valid && (outstanding != '0);
  assign push            = rsp_fire && (drop_cnt == '0) && !redirect_valid;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_fire);

  assign instr_valid = (fifo_count != '0) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign instr       = (fifo_count != '0) ? fifo_data[fifo_rd] : '0;
  assign instr_pc    = (fifo_count != '0) ? fifo_pc[fifo_rd]   : '0;

  assign imm_ext    = A_WIDTH'($signed(immop));
  assign target_sum = redirect_pc + imm_ext;
  assign target     = {target_sum[A_WIDTH-1:2], 2'b00};

  // Control state; a redirect flushes everything and turns all in-flight fetches into drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      running     <= 1'b0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      running     <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        pc         <= target;
        drop_cnt   <= outstanding_nxt;
        fifo_count <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        tag_wr     <= '0;
        tag_rd     <= '0;
      end else begin
        if (req_fire) begin
          pc     <= pc + A_WIDTH'(4);
          tag_wr <= tag_wr + PW'(1);
        end
        if (rsp_fire && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          fifo_wr <= fifo_wr + PW'(1);
          tag_rd  <= tag_rd + PW'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + PW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: the count and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[fifo_wr] <= imem_rsp_data;
      fifo_pc[fifo_wr]   <= tag_q[tag_rd];
    end
    if (req_fire && !redirect_valid) begin
      tag_q[tag_wr] <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-randomised memory model plus a
// program-order model of the fetch address and delivered instruction streams.
module tb_fetch_unit;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk;
  logic          rst_n;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [DW-1:0] immop;

  fetch_unit #(
    .A_WIDTH (AW),
    .D_WIDTH (DW),
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .immop         (immop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          checks;
  int          errors;
  int          cyc;
  int          accepts;
  int          delivered;
  int          rdy_pct;
  int          irdy_pct;
  int          redir_pct;
  int          lat_min;
  int          lat_max;
  logic [31:0] exp_fetch;
  logic [31:0] exp_pc;
  logic        force_redir;
  logic [31:0] force_rpc;
  logic [31:0] force_imm;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus();
    int v;
    @(posedge clk);
    #1;
    cyc++;
    imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
    instr_ready    = (int'($urandom_range(99)) < irdy_pct);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_rpc;
      immop          = force_imm;
      force_redir    = 1'b0;
    end else if (int'($urandom_range(99)) < redir_pct) begin
      v              = int'($urandom_range(0, 511)) - 256;
      redirect_valid = 1'b1;
      redirect_pc    = $urandom;
      immop          = 32'(v);
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      immop          = $urandom;
    end
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // Observes the cycle on the falling edge, checks it against the program-order model, then advances the model.
  task automatic checkOutput();
    logic [31:0] t;
    @(negedge clk);
    if (imem_req_valid) expectEq("req_addr", imem_req_addr, exp_fetch);
    if (redirect_valid) expectEq("no_handshake_on_redirect", 32'(instr_valid), 32'd0);
    if (instr_valid && instr_ready) begin
      expectEq("instr_pc", instr_pc, exp_pc);
      expectEq("instr", instr, memWord(exp_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (imem_rsp_valid) void'(memq.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      memq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_min, lat_max))});
      exp_fetch = exp_fetch + 32'd4;
      accepts++;
    end
    if (redirect_valid) begin
      t         = redirect_pc + immop;
      t[1:0]    = 2'b00;
      exp_fetch = t;
      exp_pc    = t;
    end
  endtask

  task automatic step();
    applyStimulus();
    checkOutput();
  endtask

  task automatic drain(input int n);
    rdy_pct = 0;
    repeat (n) step();
  endtask

  task automatic checkResetOutputs(input string tag);
    expectEq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    expectEq({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    expectEq({tag, "_instr"}, instr, 32'd0);
    expectEq({tag, "_instr_pc"}, instr_pc, 32'd0);
  endtask

  initial begin
    int a0;
    int d0;
    checks = 0; errors = 0; cyc = 0; accepts = 0; delivered = 0;
    rdy_pct = 100; irdy_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
    force_redir = 1'b0; force_rpc = '0; force_imm = '0;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; immop = '0;
    exp_fetch = RESET_PC;
    exp_pc    = RESET_PC;

    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line streaming with an always-ready memory.
    $display("[TB] sequential stream");
    repeat (20) step();
    expectEq("stream_progress", 32'(delivered >= 8), 32'd1);

    // Decode stalled: the fetch budget must cap requests.
    $display("[TB] decode stall");
    irdy_pct = 0;
    a0 = accepts;
    repeat (10) step();
    expectEq("stall_accepts_le_depth", 32'(accepts - a0 <= DEPTH), 32'd1);
    expectEq("stall_req_valid_low", 32'(imem_req_valid), 32'd0);
    irdy_pct = 100;
    rdy_pct  = 100;
    d0 = delivered;
    repeat (20) step();
    expectEq("stall_release_progress", 32'(delivered - d0 >= 4), 32'd1);

    // Memory not ready: the request address holds.
    $display("[TB] request hold");
    drain(6);
    force_redir = 1'b1; force_rpc = 32'h10; force_imm = 32'h0;
    step();
    repeat (3) begin
      step();
      expectEq("hold_req_valid", 32'(imem_req_valid), 32'd1);
      expectEq("hold_addr", imem_req_addr, 32'h10);
    end
    rdy_pct = 100;
    step();
    step();
    expectEq("after_hold_addr", imem_req_addr, 32'h14);

    // Redirect with two fetches in flight.
    $display("[TB] redirect with fetches in flight");
    drain(6);
    lat_min = 3; lat_max = 3; rdy_pct = 100;
    step();
    step();
    force_redir = 1'b1; force_rpc = 32'h20; force_imm = 32'hFFFF_FFF8;
    step();
    step();
    expectEq("redirect_target_addr", imem_req_addr, 32'h18);
    d0 = delivered;
    repeat (15) step();
    expectEq("redirect_progress", 32'(delivered - d0 >= 2), 32'd1);

    // Redirect coinciding with a request accept and a response.
    $display("[TB] redirect with accept and response");
    lat_min = 1; lat_max = 1;
    drain(6);
    rdy_pct = 100;
    step();
    force_redir = 1'b1; force_rpc = 32'h100; force_imm = 32'h40;
    step();
    d0 = delivered;
    repeat (10) step();
    expectEq("coincident_redirect_progress", 32'(delivered - d0 >= 2), 32'd1);

    // Address wrap and a misaligned target.
    $display("[TB] wrap and alignment");
    force_redir = 1'b1; force_rpc = 32'hFFFF_FFF0; force_imm = 32'hC;
    step();
    step();
    expectEq("wrap_start_addr", imem_req_addr, 32'hFFFF_FFFC);
    d0 = delivered;
    repeat (10) step();
    expectEq("wrap_progress", 32'(delivered - d0 >= 3), 32'd1);
    force_redir = 1'b1; force_rpc = 32'h2; force_imm = 32'h4;
    step();
    step();
    expectEq("aligned_target_addr", imem_req_addr, 32'h4);
    repeat (10) step();

    // Randomised traffic with random redirects and memory latency.
    $display("[TB] random traffic");
    rdy_pct = 70; irdy_pct = 70; redir_pct = 5; lat_min = 1; lat_max = 4;
    repeat (400) step();
    rdy_pct = 100; irdy_pct = 100; redir_pct = 0;
    d0 = delivered;
    repeat (30) step();
    expectEq("random_final_progress", 32'(delivered - d0 >= 5), 32'd1);

    // Reset pulsed mid-stream.
    $display("[TB] mid-stream reset");
    #2;
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    checkResetOutputs("midreset");
    memq.delete();
    exp_fetch = RESET_PC;
    exp_pc    = RESET_PC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat_min = 1; lat_max = 1;
    d0 = delivered;
    repeat (12) step();
    expectEq("restart_progress", 32'(delivered - d0 >= 3), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
